period_meter: RTL
=================

// Module: period_meter
// PURPOSE
//  Measures the half-period of a slow square wave (e.g. a divided clock) in units of clk cycles.
//  This is the receive-side counterpart of the frequency divider: a divider with coefficient N
//  produces a toggle every N enabled clocks, and this block reports N for each half-period.
//  It sits between the keyboard/light-box scan clocks and the control logic, and checks their rates.
// PARAMETERS
//  CNTR_WIDTH    8    width of the measurement counter and of half_period
//  MAX_COUNT     255  counter value at which the timeout state is entered; must be <= 2**CNTR_WIDTH-1
//  DEGLITCH_LEN  3    stable cycles required before a level change is accepted; used only with the macro
// PORTS
//  clk          in   1           system clock; all logic is on its rising edge
//  rst          in   1           synchronous reset, active-high
//  enable       in   1           measurement enable; low forces IDLE
//  sig_in       in   1           asynchronous square wave to measure
//  half_period  out  CNTR_WIDTH  last valid half-period in clk cycles
//  half_level   out  1           level of sig_in during the reported half-period
//  period_valid out  1           one-cycle strobe; half_period/half_level were updated this cycle
//  timeout      out  1           high while no edge has been seen for MAX_COUNT cycles
// BEHAVIOUR
//  Reset: all outputs are 0, the counter is 0, state is IDLE, and the sync flops are 0.
//  Input path: a two-flop synchronizer, then a third flop s3. edge = s2 ^ s3.
//   The first sampled transition of sig_in produces period_valid 3 clk cycles later.
//  States: IDLE, MEASURE, TIMEOUT.
//   IDLE: cntr = 0. On edge, go to MEASURE with cntr <= 1. No strobe.
//   MEASURE, no edge: cntr <= cntr + 1. If cntr == MAX_COUNT, go to TIMEOUT and set timeout <= 1.
//   MEASURE, edge: half_period <= cntr, half_level <= s3, period_valid <= 1, cntr <= 1, stay.
//    With a clean input of N-cycle half-periods, half_period = N exactly.
//   TIMEOUT: cntr holds. On edge, go to MEASURE with cntr <= 1 and timeout <= 0.
//    No strobe here, because the half-period is out of range.
//  Boundaries:
//   - An edge in the same cycle as cntr == MAX_COUNT: the edge wins; MAX_COUNT is reported as valid.
//   - The counter never wraps; MAX_COUNT saturates into TIMEOUT.
//   - enable low: go to IDLE, cntr <= 0, timeout <= 0, period_valid <= 0.
//     half_period and half_level hold.
//   - enable rising: the first edge only arms the measurement. The first strobe comes on the second edge.
//   - rst mid-measurement: the full reset values apply on the next clock and override enable.
//   - period_valid is never high for two consecutive cycles unless N == 1.
//  Arithmetic: cntr is unsigned, CNTR_WIDTH bits. There is no averaging or rounding.
// CONFIGURATION
//  PERIOD_METER_DEGLITCH_EN defined:
//   - A filter stage after the synchronizer feeds s3.
//   - A new level is accepted only after it has been stable for DEGLITCH_LEN consecutive cycles.
//   - Pulses shorter than DEGLITCH_LEN cycles are ignored.
//   - Latency grows by DEGLITCH_LEN cycles. Values for clean input are unchanged.
//  PERIOD_METER_DEGLITCH_EN undefined: there is no filter, s3 is fed directly from s2,
//   and DEGLITCH_LEN is ignored.
// STRUCTURE
//  period_meter_pkg holds:
//   - the state enum (ST_IDLE, ST_MEASURE, ST_TIMEOUT);
//   - the default CNTR_WIDTH and MAX_COUNT localparams.
//  One sub-module, period_meter_edge_sync, contains the synchronizer, the optional deglitch filter,
//   s3 and the edge/level outputs. The top level contains the FSM and the counter.
// TESTING
//  1 Reset, then enable=1 with sig_in toggling every 5 clk:
//    no strobe on the first edge, then half_period=5 on every strobe,
//    with half_level alternating 1/0 and timeout=0.
//  2 sig_in high for 7 cycles, low for 3, repeated: strobes alternate half_period=7 with
//    half_level=1 and half_period=3 with half_level=0.
//  3 MAX_COUNT=20, sig_in held static: timeout=1 once cntr reaches 20. The next edge clears
//    timeout with no strobe; the following edge 6 cycles later gives half_period=6.
//  4 An edge arriving exactly when cntr==MAX_COUNT: half_period=MAX_COUNT, timeout stays 0.
//  5 rst pulsed mid-measurement while half_period=9: all outputs are 0 next cycle,
//    and the first strobe comes on the second edge after release.
//    Dropping enable mid-measurement: half_period holds 9, no strobe.
//  6 With the macro and DEGLITCH_LEN=3, 2-cycle glitches on a 10-cycle wave: half_period=10 always.
//    Without the macro, the glitches produce short strobes such as 2.

Source files
------------

// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : period_meter_pkg
//  Purpose  : Shared types and default sizing for the period_meter block.
//             The state enum is used by the top-level FSM. The defaults
//             seed the parameters of period_meter and period_meter_edge_sync.
//  Macro    : PERIOD_METER_DEGLITCH_EN (consumed by period_meter_edge_sync)
//  Revision : 1.0  initial release
// ============================================================================
package period_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  // Default sizing. MAX_COUNT must fit in CNTR_WIDTH bits.
  localparam int DEF_CNTR_WIDTH   = 8;
  localparam int DEF_MAX_COUNT    = 255;
  localparam int DEF_DEGLITCH_LEN = 3;

endpackage : period_meter_pkg
`default_nettype wire

// File: rtl/period_meter_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : period_meter_edge_sync
//  Purpose  : Brings the asynchronous square wave into the clk domain.
//             A two-flop synchronizer is followed by an optional deglitch
//             filter, then by s3. The block flags a level change
//             (edge_o = stage ^ s3) and reports the settled level (s3).
//  Macro    : PERIOD_METER_DEGLITCH_EN  - when defined, a level must hold for
//             DEGLITCH_LEN consecutive cycles before it reaches s3.
//  Revision : 1.0  initial release
// ============================================================================
module period_meter_edge_sync
  import period_meter_pkg::*;
#(
  parameter int DEGLITCH_LEN = DEF_DEGLITCH_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic edge_o,
  output logic level_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic s3_d;

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
    end
  end

`ifdef PERIOD_METER_DEGLITCH_EN
  // Counter width covers 0..DEGLITCH_LEN-1. A length of 1 still needs one bit.
  localparam int c_dg_w = (DEGLITCH_LEN > 1) ? $clog2(DEGLITCH_LEN) : 1;
  localparam logic [c_dg_w-1:0] c_dg_last = c_dg_w'(DEGLITCH_LEN - 1);
  localparam logic [c_dg_w-1:0] c_dg_one  = c_dg_w'(1);

  logic              filt_q;
  logic [c_dg_w-1:0] dg_cnt_q;

  // Accept a new level only after it has differed from the filtered level
  // for DEGLITCH_LEN consecutive cycles. Any return to the old level restarts
  // the count, so shorter pulses never reach s3.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= 1'b0;
      dg_cnt_q <= '0;
    end else if (s2_q == filt_q) begin
      dg_cnt_q <= '0;
    end else if (dg_cnt_q == c_dg_last) begin
      filt_q   <= s2_q;
      dg_cnt_q <= '0;
    end else begin
      dg_cnt_q <= dg_cnt_q + c_dg_one;
    end
  end

  assign s3_d = filt_q;
`else
  assign s3_d = s2_q;
`endif

  // s3 holds the previous stage value, so stage ^ s3 marks one-cycle edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q <= 1'b0;
    end else begin
      s3_q <= s3_d;
    end
  end

  assign edge_o  = s3_d ^ s3_q;
  assign level_o = s3_q;

endmodule : period_meter_edge_sync
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : period_meter
//  Purpose  : Measures each half-period of a slow square wave in clk cycles.
//             An FSM (IDLE / MEASURE / TIMEOUT) and a saturating counter run
//             behind period_meter_edge_sync. Each accepted edge reports the
//             count and the level of the half-period that just ended.
//  Macro    : PERIOD_METER_DEGLITCH_EN  - enables the input deglitch filter
//             (DEGLITCH_LEN stable cycles) inside period_meter_edge_sync.
//  Revision : 1.0  initial release
// ============================================================================
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNTR_WIDTH   = DEF_CNTR_WIDTH,
  parameter int MAX_COUNT    = DEF_MAX_COUNT,
  parameter int DEGLITCH_LEN = DEF_DEGLITCH_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sig_in,
  output logic [CNTR_WIDTH-1:0] half_period,
  output logic                  half_level,
  output logic                  period_valid,
  output logic                  timeout
);

  localparam logic [CNTR_WIDTH-1:0] c_max_count = CNTR_WIDTH'(MAX_COUNT);
  localparam logic [CNTR_WIDTH-1:0] c_one       = CNTR_WIDTH'(1);

  logic                  edge_w;
  logic                  level_w;

  state_e                state_q;
  logic [CNTR_WIDTH-1:0] cntr_q;
  logic [CNTR_WIDTH-1:0] half_period_q;
  logic                  half_level_q;
  logic                  period_valid_q;
  logic                  timeout_q;

  period_meter_edge_sync #(
    .DEGLITCH_LEN (DEGLITCH_LEN)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (sig_in),
    .edge_o  (edge_w),
    .level_o (level_w)
  );

  // Measurement FSM with counter and registered outputs. The counter is 1 in
  // the cycle of the arming edge, so a clean N-cycle half-period reads N.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cntr_q         <= '0;
      half_period_q  <= '0;
      half_level_q   <= 1'b0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else if (!enable) begin
      // Results hold while disabled. Only the live measurement is dropped.
      state_q        <= ST_IDLE;
      cntr_q         <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The first edge only arms; its half-period start is unknown
          cntr_q <= '0;
          if (edge_w) begin
            state_q <= ST_MEASURE;
            cntr_q  <= c_one;
          end
        end

        ST_MEASURE: begin
          // An edge takes priority over saturation, so a half-period of
          // exactly MAX_COUNT is still reported
          if (edge_w) begin
            half_period_q  <= cntr_q;
            half_level_q   <= level_w;
            period_valid_q <= 1'b1;
            cntr_q         <= c_one;
          end else if (cntr_q == c_max_count) begin
            state_q   <= ST_TIMEOUT;
            timeout_q <= 1'b1;
          end else begin
            cntr_q <= cntr_q + c_one;
          end
        end

        ST_TIMEOUT: begin
          // An out-of-range half-period is dropped. The edge re-arms.
          if (edge_w) begin
            state_q   <= ST_MEASURE;
            cntr_q    <= c_one;
            timeout_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          cntr_q    <= '0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign half_period  = half_period_q;
  assign half_level   = half_level_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;

endmodule : period_meter
`default_nettype wire
